// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control FSM:
// states, opcodes, instruction classes, ALUOp and PCSrc.
package mc_ctrl_pkg;

   localparam int OPC_WIDTH   = 6;
   localparam int FUNCT_WIDTH = 6;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB
   } state_t;

   typedef enum logic [2:0] {
      CL_R,
      CL_LW,
      CL_SW,
      CL_IMM,
      CL_BEQ,
      CL_J,
      CL_ILL
   } iclass_t;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_IMM   = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10
   } pc_src_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Fetch-side handshake into the control FSM, plus the
// latched instruction fields it hands on to the datapath.
interface mc_control_fsm_if
   import mc_ctrl_pkg::*;
#(
   parameter int OPC_W   = OPC_WIDTH,
   parameter int FUNCT_W = FUNCT_WIDTH
);

   logic               instr_valid;
   logic               instr_ready;
   logic [OPC_W-1:0]   opcode;
   logic [FUNCT_W-1:0] funct;
   logic [OPC_W-1:0]   ir_opcode;
   logic [FUNCT_W-1:0] ir_funct;

   modport master (
      output instr_valid, opcode, funct,
      input  instr_ready, ir_opcode, ir_funct
   );

   modport slave (
      input  instr_valid, opcode, funct,
      output instr_ready, ir_opcode, ir_funct
   );

endinterface

// File: rtl/mc_main_decoder.sv
// Main decoder: latched opcode -> instruction class, the
// ALUOp used in EXEC/WB and the operand-B immediate select.
module mc_main_decoder
   import mc_ctrl_pkg::*;
#(
   parameter int OPC_W = OPC_WIDTH
) (
   input  logic [OPC_W-1:0] opcode,
   output iclass_t          iclass,
   output alu_op_t          alu_op,
   output logic             src_imm
);

   // classify opcode; anything unlisted is illegal
   always_comb begin
      iclass  = CL_ILL;
      alu_op  = ALU_ADD;
      src_imm = 1'b0;
      unique case (1'b1)
         (opcode == OP_R): begin
            iclass = CL_R;
            alu_op = ALU_FUNCT;
         end
         (opcode == OP_LW): begin
            iclass  = CL_LW;
            src_imm = 1'b1;
         end
         (opcode == OP_SW): begin
            iclass  = CL_SW;
            src_imm = 1'b1;
         end
         (opcode == OP_ADDI): begin
            iclass  = CL_IMM;
            src_imm = 1'b1;
         end
         (opcode == OP_ANDI),
         (opcode == OP_ORI),
         (opcode == OP_SLTI): begin
            iclass  = CL_IMM;
            alu_op  = ALU_IMM;
            src_imm = 1'b1;
         end
         (opcode == OP_BEQ): begin
            iclass = CL_BEQ;
            alu_op = ALU_SUB;
         end
         (opcode == OP_J): begin
            iclass = CL_J;
         end
         default: begin
            iclass = CL_ILL;
         end
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Define INSTR_COUNT_EN to add the retired-instruction counter.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OPC_W   = OPC_WIDTH,
   parameter int FUNCT_W = FUNCT_WIDTH
`ifdef INSTR_COUNT_EN
   ,
   parameter int CNT_W   = 32
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mc_control_fsm_if.slave       fif,
   input  logic                  mem_ready,
   input  logic                  zero,
   output logic                  IRWrite,
   output logic                  MUXsel,
   output logic                  RegDst,
   output logic                  RegWrite,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  MemtoReg,
   output logic [1:0]            ALUOp,
   output logic                  PCWrite,
   output logic [1:0]            PCSrc,
   output logic                  illegal
`ifdef INSTR_COUNT_EN
   ,
   output logic [CNT_W-1:0]      instr_count
`endif
);

   state_t             state;
   state_t             state_nx;
   logic [OPC_W-1:0]   op_q;
   logic [FUNCT_W-1:0] fn_q;
   iclass_t            iclass;
   alu_op_t            dec_alu;
   logic               src_imm;

   mc_main_decoder #(
      .OPC_W (OPC_W)
   ) u_dec (
      .opcode  (op_q),
      .iclass  (iclass),
      .alu_op  (dec_alu),
      .src_imm (src_imm)
   );

   assign fif.ir_opcode = op_q;
   assign fif.ir_funct  = fn_q;

   // state register; instruction fields latch only on the fetch handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_FETCH;
         op_q  <= '0;
         fn_q  <= '0;
      end else begin
         state <= state_nx;
         if (IRWrite) begin
            op_q <= fif.opcode;
            fn_q <= fif.funct;
         end
      end
   end

   // next state and control outputs from state + latched class
   always_comb begin
      state_nx        = state;
      fif.instr_ready = 1'b0;
      IRWrite         = 1'b0;
      MUXsel          = 1'b0;
      RegDst          = 1'b0;
      RegWrite        = 1'b0;
      MemRead         = 1'b0;
      MemWrite        = 1'b0;
      MemtoReg        = 1'b0;
      ALUOp           = ALU_ADD;
      PCWrite         = 1'b0;
      PCSrc           = PC_SEQ;
      illegal         = 1'b0;
      unique case (state)
         ST_FETCH: begin
            fif.instr_ready = 1'b1;
            if (fif.instr_valid && rst_n) begin
               IRWrite  = 1'b1;
               state_nx = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (iclass == CL_J) begin
               PCWrite  = 1'b1;
               PCSrc    = PC_JUMP;
               state_nx = ST_FETCH;
            end else if (iclass == CL_ILL) begin
               illegal  = 1'b1;
               PCWrite  = 1'b1;
               state_nx = ST_FETCH;
            end else begin
               state_nx = ST_EXEC;
            end
         end
         ST_EXEC: begin
            MUXsel = src_imm;
            ALUOp  = dec_alu;
            if (iclass == CL_BEQ) begin
               PCWrite  = 1'b1;
               PCSrc    = zero ? PC_BRANCH : PC_SEQ;
               state_nx = ST_FETCH;
            end else if (iclass == CL_LW || iclass == CL_SW) begin
               state_nx = ST_MEM;
            end else begin
               state_nx = ST_WB;
            end
         end
         ST_MEM: begin
            MUXsel   = 1'b1;
            MemRead  = (iclass == CL_LW);
            MemWrite = (iclass == CL_SW);
            if (mem_ready) begin
               if (iclass == CL_SW) begin
                  PCWrite  = 1'b1;
                  state_nx = ST_FETCH;
               end else begin
                  state_nx = ST_WB;
               end
            end
         end
         ST_WB: begin
            RegWrite = 1'b1;
            RegDst   = (iclass == CL_R);
            MemtoReg = (iclass == CL_LW);
            MUXsel   = src_imm;
            ALUOp    = dec_alu;
            PCWrite  = 1'b1;
            state_nx = ST_FETCH;
         end
         default: begin
            state_nx = ST_FETCH;
         end
      endcase
   end

`ifdef INSTR_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // count retiring PC updates; illegal opcodes do not retire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (PCWrite && !illegal) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: random instruction
// stream against a per-instruction behavioural profile model.
module tb_mc_control_fsm;

   typedef struct packed {
      int cyc;
      int pc_src;
      int n_reg;
      int reg_dst;
      int m2r;
      int n_rd;
      int n_wr;
      int n_ill;
      int n_mux;
      int alu;
      int ovl;
      int cnt;
      int ir_op;
      int ir_fn;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mem_ready = 1'b0;
   logic       zero = 1'b0;
   logic       IRWrite, MUXsel, RegDst, RegWrite;
   logic       MemRead, MemWrite, MemtoReg;
   logic [1:0] ALUOp;
   logic       PCWrite;
   logic [1:0] PCSrc;
   logic       illegal;
`ifdef INSTR_COUNT_EN
   logic [3:0] instr_count;
   localparam int CMOD = 16;
`endif

   int   vectors = 0;
   int   miscompares = 0;
   rec_t exp_q[$];
   int   cur_wait = 0;
   int   mcnt = 0;
   int   cnt_model = 0;
   bit   active = 1'b0;
   rec_t a;
   rec_t e;

   mc_control_fsm_if #(.OPC_W(6), .FUNCT_W(6)) fif ();

   mc_control_fsm #(
      .OPC_W   (6),
      .FUNCT_W (6)
`ifdef INSTR_COUNT_EN
      ,
      .CNT_W   (4)
`endif
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fif       (fif),
      .mem_ready (mem_ready),
      .zero      (zero),
      .IRWrite   (IRWrite),
      .MUXsel    (MUXsel),
      .RegDst    (RegDst),
      .RegWrite  (RegWrite),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .MemtoReg  (MemtoReg),
      .ALUOp     (ALUOp),
      .PCWrite   (PCWrite),
      .PCSrc     (PCSrc),
      .illegal   (illegal)
`ifdef INSTR_COUNT_EN
      ,
      .instr_count (instr_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic string fmt(input rec_t r);
      return $sformatf(
         "cyc=%0d pcsrc=%0d reg=%0d dst=%0d m2r=%0d rd=%0d wr=%0d ill=%0d mux=%0d alu=%0d ovl=%0d cnt=%0d ir=%0h/%0h",
         r.cyc, r.pc_src, r.n_reg, r.reg_dst, r.m2r, r.n_rd, r.n_wr,
         r.n_ill, r.n_mux, r.alu, r.ovl, r.cnt, r.ir_op, r.ir_fn);
   endfunction

   // Whole-instruction profile from the instruction-set table.
   function automatic rec_t model(input logic [5:0] op,
                                  input logic [5:0] fn,
                                  input logic z, input int w);
      rec_t r;
      r = '0;
      r.ir_op = 32'(op);
      r.ir_fn = 32'(fn);
      r.cyc = 2;
      case (op)
         6'h00: begin
            r.cyc = 4; r.n_reg = 1; r.reg_dst = 1; r.alu = 2;
         end
         6'h23: begin
            r.cyc = 5 + w; r.n_reg = 1; r.m2r = 1;
            r.n_rd = w + 1; r.n_mux = w + 3;
         end
         6'h2B: begin
            r.cyc = 4 + w; r.n_wr = w + 1; r.n_mux = w + 2;
         end
         6'h08: begin
            r.cyc = 4; r.n_reg = 1; r.n_mux = 2;
         end
         6'h0C, 6'h0D, 6'h0A: begin
            r.cyc = 4; r.n_reg = 1; r.n_mux = 2; r.alu = 3;
         end
         6'h04: begin
            r.cyc = 3; r.pc_src = z ? 1 : 0; r.alu = 1;
         end
         6'h02: begin
            r.pc_src = 2;
         end
         default: begin
            r.n_ill = 1;
         end
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      vectors++;
      if (act != req) begin
         miscompares++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Call at posedge+1; leaves garbage on the bus after the handshake.
   task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input int w);
      int   guard;
      rec_t r;
      guard = 0;
      while (!fif.instr_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!fif.instr_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL fetch_timeout: instr_ready=0 after %0d cycles, required 1", guard);
         return;
      end
      if ($urandom_range(0, 3) == 0) begin
         fif.instr_valid = 1'b0;
         @(posedge clk); #1;
      end
      r = model(op, fn, z, w);
`ifdef INSTR_COUNT_EN
      r.cnt = cnt_model;
      if (r.n_ill == 0) cnt_model = (cnt_model + 1) % CMOD;
`endif
      exp_q.push_back(r);
      fif.instr_valid = 1'b1;
      fif.opcode = op;
      fif.funct = fn;
      zero = z;
      cur_wait = w;
      @(posedge clk); #1;
      fif.instr_valid = 1'($urandom_range(0, 1));
      fif.opcode = 6'($urandom);
      fif.funct = 6'($urandom);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      fif.instr_valid = 1'b0;
      while ((exp_q.size() != 0 || active) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      vectors++;
      if (exp_q.size() != 0 || active) begin
         miscompares++;
         $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
      end
   endtask

   // memory model: assert mem_ready after cur_wait stalled cycles
   initial forever begin
      @(posedge clk); #1;
      if (MemRead || MemWrite) begin
         mem_ready = (mcnt == cur_wait);
         mcnt++;
      end else begin
         mem_ready = 1'b0;
         mcnt = 0;
      end
   end

   // monitor: build each instruction's profile, compare at its PCWrite
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         active = 1'b0;
         continue;
      end
      if (!active && IRWrite) begin
         active = 1'b1;
         a = '0;
      end
      if (active) begin
         a.cyc++;
         if (MUXsel) a.n_mux++;
         if (MemRead) a.n_rd++;
         if (MemWrite) a.n_wr++;
         if (illegal) a.n_ill++;
         if (RegWrite) begin
            a.n_reg++;
            a.reg_dst = RegDst ? 1 : 0;
            a.m2r = MemtoReg ? 1 : 0;
         end
         if ($countones({IRWrite, RegWrite, MemRead, MemWrite}) > 1)
            a.ovl++;
         if (PCWrite) begin
            a.pc_src = 32'(PCSrc);
            a.alu = 32'(ALUOp);
            a.ir_op = 32'(fif.ir_opcode);
            a.ir_fn = 32'(fif.ir_funct);
`ifdef INSTR_COUNT_EN
            a.cnt = 32'(instr_count);
`endif
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL retire_unexpected: actual %s", fmt(a));
            end else begin
               e = exp_q.pop_front();
               if (a !== e) begin
                  miscompares++;
                  $display("FAIL instr: actual %s required %s", fmt(a), fmt(e));
               end
            end
            active = 1'b0;
         end
      end else begin
         vectors++;
         if ({PCWrite, RegWrite, MemRead, MemWrite, illegal} != 5'b0) begin
            miscompares++;
            $display("FAIL idle_enables: actual=%b required 00000",
                     {PCWrite, RegWrite, MemRead, MemWrite, illegal});
         end
      end
   end

   logic [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C,
                           6'h0D, 6'h0A, 6'h04, 6'h02};

   initial begin
      int k;
      fif.instr_valid = 1'b0;
      fif.opcode = '0;
      fif.funct = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(fif.instr_ready), 1);
      chk("rst_irwrite", 32'(IRWrite), 0);
      chk("rst_enables", 32'({MUXsel, RegDst, RegWrite, MemRead,
                              MemWrite, MemtoReg, PCWrite, illegal}), 0);
      chk("rst_aluop", 32'(ALUOp), 0);
      chk("rst_pcsrc", 32'(PCSrc), 0);
      chk("rst_ir_opcode", 32'(fif.ir_opcode), 0);
`ifdef INSTR_COUNT_EN
      chk("rst_count", 32'(instr_count), 0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(6'h00, 6'h20, 1'b0, 0);
      issue(6'h23, 6'h00, 1'b0, 3);
      issue(6'h2B, 6'h11, 1'b1, 0);
      issue(6'h04, 6'h00, 1'b1, 0);
      issue(6'h04, 6'h00, 1'b0, 0);
      issue(6'h02, 6'h3F, 1'b0, 0);
      issue(6'h3F, 6'h00, 1'b0, 0);
      issue(6'h08, 6'h05, 1'b0, 0);
      issue(6'h0C, 6'h05, 1'b0, 0);
      issue(6'h0D, 6'h05, 1'b1, 0);
      issue(6'h0A, 6'h05, 1'b0, 0);
      issue(6'h2B, 6'h00, 1'b0, 3);

      for (int i = 0; i < 250; i++) begin
         k = $urandom_range(0, 10);
         issue((k < 9) ? ops[k] : 6'($urandom), 6'($urandom),
               1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
      drain();

      // async reset while lw waits in MEM
      @(posedge clk); #1;
      issue(6'h23, 6'h00, 1'b0, 60);
      fif.instr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_mem_read", 32'(MemRead), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_memread", 32'(MemRead), 0);
      chk("rst_async_ready", 32'(fif.instr_ready), 1);
      chk("rst_async_ir", 32'(fif.ir_opcode), 0);
`ifdef INSTR_COUNT_EN
      chk("rst_async_count", 32'(instr_count), 0);
`endif
      exp_q.delete();
      cnt_model = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++)
         issue(6'h08, 6'($urandom), 1'b0, 0);
      drain();
      @(posedge clk); #1;
`ifdef INSTR_COUNT_EN
      chk("count_wrap", 32'(instr_count), 1);
`endif
      chk("final_ready", 32'(fif.instr_ready), 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
